// File: rtl/tl_tx_arbiter_if.sv
// Framed 256-bit TLP stream from the TX arbiter toward the data link layer.
// The arbiter drives the beat; the link layer answers with ready.
interface tl_tx_arbiter_if;
    logic         tlp_valid;
    logic [255:0] tlp_data;
    logic         tlp_sop;
    logic         tlp_eop;
    logic         tlp_half;
    logic         tlp_ready;

    modport master (
        output tlp_valid,
        output tlp_data,
        output tlp_sop,
        output tlp_eop,
        output tlp_half,
        input  tlp_ready
    );

    modport slave (
        input  tlp_valid,
        input  tlp_data,
        input  tlp_sop,
        input  tlp_eop,
        input  tlp_half,
        output tlp_ready
    );
endinterface

// File: rtl/tl_tx_arbiter.sv
// TX arbiter/framer: picks posted or non-posted TLPs under flow-control credits
// and shifts 4DW headers into 256-bit beats, carrying the upper half of each data word.
module tl_tx_arbiter #(
    parameter int PH_W  = 8,
    parameter int PD_W  = 12,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               p_hdr_empty_i,
    input  logic [127:0]       p_hdr_rdata_i,
    output logic               p_hdr_rden_o,
    input  logic               p_data_empty_i,
    input  logic [255:0]       p_data_rdata_i,
    output logic               p_data_rden_o,
    input  logic [CNT_W-1:0]   p_payload_cnt_i,
    output logic               p_sent_o,
    input  logic               np_hdr_empty_i,
    input  logic [127:0]       np_hdr_rdata_i,
    output logic               np_hdr_rden_o,
    input  logic [PH_W-1:0]    fc_ph_limit_i,
    input  logic [PD_W-1:0]    fc_pd_limit_i,
    input  logic [PH_W-1:0]    fc_nph_limit_i,
    tl_tx_arbiter_if.master    tx
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_P_HDR  = 3'd1,
        ST_P_DATA = 3'd2,
        ST_P_TAIL = 3'd3,
        ST_NP     = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [127:0]     carry_r;
    logic [7:0]       rem_r;
    logic [7:0]       nb_r;
    logic [PH_W-1:0]  ph_c_r;
    logic [PD_W-1:0]  pd_c_r;
    logic [PH_W-1:0]  nph_c_r;

    logic [7:0]       hdr_nb_s;
    logic             p_elig_s;
    logic             np_elig_s;
    logic             valid_s;
    logic             accept_s;

    // Payload beats of a posted header; a zero length field encodes 1024 DW.
    function automatic logic [7:0] beats_of(input logic [127:0] hdr);
        logic len_zero;
        len_zero = (hdr[17:16] == 2'b00) && (hdr[31:24] == 8'h00);
        if (len_zero) begin
            return 8'd128;
        end else begin
            return {1'b0, hdr[17:16], hdr[31:27]};
        end
    endfunction

    // Payloads are whole 32-byte beats, so PD credits are simply two per beat.
    function automatic logic [PD_W-1:0] pd_need(input logic [7:0] nb);
        logic [PD_W-1:0] ext;
        ext      = {PD_W{1'b0}};
        ext[8:1] = nb;
        return ext;
    endfunction

    function automatic logic ph_pass(input logic [PH_W-1:0] limit,
                                     input logic [PH_W-1:0] used);
        logic [PH_W-1:0] diff;
        diff = limit - used - {{(PH_W-1){1'b0}}, 1'b1};
        return ~diff[PH_W-1];
    endfunction

    function automatic logic pd_pass(input logic [PD_W-1:0] limit,
                                     input logic [PD_W-1:0] used,
                                     input logic [PD_W-1:0] need);
        logic [PD_W-1:0] diff;
        diff = limit - used - need;
        return ~diff[PD_W-1];
    endfunction

    // Eligibility of each class; only acted upon while idle.
    always_comb begin
        hdr_nb_s  = beats_of(p_hdr_rdata_i);
        p_elig_s  = (p_payload_cnt_i != {CNT_W{1'b0}}) && !p_hdr_empty_i &&
                    ph_pass(fc_ph_limit_i, ph_c_r) &&
                    pd_pass(fc_pd_limit_i, pd_c_r, pd_need(hdr_nb_s));
        np_elig_s = !np_hdr_empty_i && ph_pass(fc_nph_limit_i, nph_c_r);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; posted traffic wins over non-posted.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (p_elig_s) begin
                    state_s = ST_P_HDR;
                end else if (np_elig_s) begin
                    state_s = ST_NP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_P_HDR: begin
                if (accept_s) begin
                    if (nb_r == 8'd1) begin
                        state_s = ST_P_TAIL;
                    end else begin
                        state_s = ST_P_DATA;
                    end
                end else begin
                    state_s = ST_P_HDR;
                end
            end
            ST_P_DATA: begin
                if (accept_s && (rem_r == 8'd1)) begin
                    state_s = ST_P_TAIL;
                end else begin
                    state_s = ST_P_DATA;
                end
            end
            ST_P_TAIL: begin
                if (accept_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_P_TAIL;
                end
            end
            ST_NP: begin
                if (accept_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_NP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Beat formation and FIFO pops; pops happen only on the accepting handshake.
    always_comb begin
        valid_s      = 1'b0;
        tx.tlp_data  = 256'd0;
        tx.tlp_sop   = 1'b0;
        tx.tlp_eop   = 1'b0;
        tx.tlp_half  = 1'b0;
        case (state_r)
            ST_P_HDR: begin
                valid_s     = 1'b1;
                tx.tlp_data = {p_data_rdata_i[127:0], p_hdr_rdata_i};
                tx.tlp_sop  = 1'b1;
            end
            ST_P_DATA: begin
                valid_s     = !p_data_empty_i;
                tx.tlp_data = {p_data_rdata_i[127:0], carry_r};
            end
            ST_P_TAIL: begin
                valid_s     = 1'b1;
                tx.tlp_data = {128'd0, carry_r};
                tx.tlp_eop  = 1'b1;
                tx.tlp_half = 1'b1;
            end
            ST_NP: begin
                valid_s     = 1'b1;
                tx.tlp_data = {128'd0, np_hdr_rdata_i};
                tx.tlp_sop  = 1'b1;
                tx.tlp_eop  = 1'b1;
                tx.tlp_half = 1'b1;
            end
            default: begin
                valid_s     = 1'b0;
                tx.tlp_data = 256'd0;
            end
        endcase
        accept_s      = valid_s && tx.tlp_ready;
        tx.tlp_valid  = valid_s;
        p_hdr_rden_o  = accept_s && (state_r == ST_P_HDR);
        p_data_rden_o = accept_s && ((state_r == ST_P_HDR) || (state_r == ST_P_DATA));
        np_hdr_rden_o = accept_s && (state_r == ST_NP);
        p_sent_o      = accept_s && (state_r == ST_P_TAIL);
    end

    // Datapath: carried half-word, beat countdown and consumed credit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_r <= 128'd0;
            rem_r   <= 8'd0;
            nb_r    <= 8'd0;
            ph_c_r  <= {PH_W{1'b0}};
            pd_c_r  <= {PD_W{1'b0}};
            nph_c_r <= {PH_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (p_elig_s) begin
                        nb_r <= hdr_nb_s;
                    end
                end
                ST_P_HDR: begin
                    if (accept_s) begin
                        carry_r <= p_data_rdata_i[255:128];
                        rem_r   <= nb_r - 8'd1;
                        ph_c_r  <= ph_c_r + {{(PH_W-1){1'b0}}, 1'b1};
                        pd_c_r  <= pd_c_r + pd_need(nb_r);
                    end
                end
                ST_P_DATA: begin
                    if (accept_s) begin
                        carry_r <= p_data_rdata_i[255:128];
                        rem_r   <= rem_r - 8'd1;
                    end
                end
                ST_NP: begin
                    if (accept_s) begin
                        nph_c_r <= nph_c_r + {{(PH_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    carry_r <= carry_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tl_tx_arbiter.sv
// Bench for tl_tx_arbiter: queue-based FIFO models plus a TLP-level reference model
// that predicts every output beat, pop and sent pulse from the header/credit rules.
module tb_tl_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         p_hdr_empty;
    logic [127:0] p_hdr_rdata;
    logic         p_hdr_rden;
    logic         p_data_empty;
    logic [255:0] p_data_rdata;
    logic         p_data_rden;
    logic [3:0]   p_payload_cnt;
    logic         p_sent;
    logic         np_hdr_empty;
    logic [127:0] np_hdr_rdata;
    logic         np_hdr_rden;
    logic [7:0]   ph_lim;
    logic [11:0]  pd_lim;
    logic [7:0]   nph_lim;

    tl_tx_arbiter_if tx();

    tl_tx_arbiter #(.PH_W(8), .PD_W(12), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .p_hdr_empty_i   (p_hdr_empty),
        .p_hdr_rdata_i   (p_hdr_rdata),
        .p_hdr_rden_o    (p_hdr_rden),
        .p_data_empty_i  (p_data_empty),
        .p_data_rdata_i  (p_data_rdata),
        .p_data_rden_o   (p_data_rden),
        .p_payload_cnt_i (p_payload_cnt),
        .p_sent_o        (p_sent),
        .np_hdr_empty_i  (np_hdr_empty),
        .np_hdr_rdata_i  (np_hdr_rdata),
        .np_hdr_rden_o   (np_hdr_rden),
        .fc_ph_limit_i   (ph_lim),
        .fc_pd_limit_i   (pd_lim),
        .fc_nph_limit_i  (nph_lim),
        .tx              (tx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic         half;
        logic         need_data;
        logic         pop_hdr;
        logic         pop_data;
    } beat_t;

    logic [127:0] p_hdr_q[$];
    logic [255:0] p_data_q[$];
    logic [127:0] np_hdr_q[$];
    logic [127:0] m_p_q[$];
    logic [255:0] m_pd_q[$];
    logic [127:0] m_np_q[$];
    beat_t        m_beats[$];
    int           m_ph_c, m_pd_c, m_nph_c, m_pdreq, payload_cnt;
    bit           m_busy, m_is_p, data_hold;
    int           checks, failures;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int len_of(input logic [127:0] h);
        return int'({22'd0, h[17:16], h[31:24]});
    endfunction

    function automatic int nb_of(input logic [127:0] h);
        return (len_of(h) == 0) ? 128 : len_of(h) / 8;
    endfunction

    function automatic int pdreq_of(input logic [127:0] h);
        return (len_of(h) == 0) ? 256 : len_of(h) / 4;
    endfunction

    function automatic bit cred_ok(input int limit, input int used, input int r, input int w);
        int m;
        int d;
        m = 1 << w;
        d = (limit - used - r) % m;
        if (d < 0) d += m;
        return d < m / 2;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic beat_t mk_beat(input logic [255:0] d, input bit sop, input bit eop,
                                      input bit half, input bit need, input bit ph, input bit pd);
        beat_t b;
        b.data = d; b.sop = sop; b.eop = eop; b.half = half;
        b.need_data = need; b.pop_hdr = ph; b.pop_data = pd;
        return b;
    endfunction

    task automatic drive();
        p_hdr_empty   = (p_hdr_q.size() == 0);
        p_hdr_rdata   = p_hdr_empty ? 128'd0 : p_hdr_q[0];
        p_data_empty  = (p_data_q.size() == 0) || data_hold;
        p_data_rdata  = (p_data_q.size() == 0) ? 256'd0 : p_data_q[0];
        np_hdr_empty  = (np_hdr_q.size() == 0);
        np_hdr_rdata  = np_hdr_empty ? 128'd0 : np_hdr_q[0];
        p_payload_cnt = payload_cnt[3:0];
    endtask

    task automatic push_p(input int len);
        logic [127:0] h;
        logic [9:0]   l10;
        logic [255:0] w;
        l10 = len[9:0];
        h = {$urandom(), $urandom(), $urandom(), $urandom()};
        h[31:24] = l10[7:0];
        h[17:16] = l10[9:8];
        p_hdr_q.push_back(h);
        m_p_q.push_back(h);
        for (int i = 0; i < nb_of(h); i++) begin
            w = rand256();
            p_data_q.push_back(w);
            m_pd_q.push_back(w);
        end
        payload_cnt++;
        drive();
    endtask

    task automatic push_np();
        logic [127:0] h;
        h = {$urandom(), $urandom(), $urandom(), $urandom()};
        np_hdr_q.push_back(h);
        m_np_q.push_back(h);
        drive();
    endtask

    // Model decision made in an idle cycle: which TLP, if any, starts next cycle.
    task automatic select();
        logic [127:0] h;
        logic [255:0] w[$];
        int nb;
        if (payload_cnt != 0 && m_p_q.size() != 0 && cred_ok(int'(ph_lim), m_ph_c, 1, 8) &&
            cred_ok(int'(pd_lim), m_pd_c, pdreq_of(m_p_q[0]), 12)) begin
            h = m_p_q.pop_front();
            nb = nb_of(h);
            m_pdreq = pdreq_of(h);
            for (int i = 0; i < nb; i++) w.push_back(m_pd_q.pop_front());
            m_beats.push_back(mk_beat({w[0][127:0], h}, 1, 0, 0, 0, 1, 1));
            for (int k = 1; k < nb; k++)
                m_beats.push_back(mk_beat({w[k][127:0], w[k-1][255:128]}, 0, 0, 0, 1, 0, 1));
            m_beats.push_back(mk_beat({128'd0, w[nb-1][255:128]}, 0, 1, 1, 0, 0, 0));
            m_busy = 1; m_is_p = 1;
        end else if (m_np_q.size() != 0 && cred_ok(int'(nph_lim), m_nph_c, 1, 8)) begin
            h = m_np_q.pop_front();
            m_beats.push_back(mk_beat({128'd0, h}, 1, 1, 1, 0, 0, 0));
            m_busy = 1; m_is_p = 0;
        end
    endtask

    task automatic tick();
        beat_t b;
        bit acc, ev, sent_now, r_ph, r_pd, r_np;
        acc = 0; sent_now = 0;
        @(negedge clk);
        if (!m_busy) begin
            chk("idle_valid", tx.tlp_valid, 0);
            chk("idle_p_hdr_rden", p_hdr_rden, 0);
            chk("idle_p_data_rden", p_data_rden, 0);
            chk("idle_np_hdr_rden", np_hdr_rden, 0);
            chk("idle_p_sent", p_sent, 0);
            select();
        end else begin
            b = m_beats[0];
            ev = b.need_data ? !p_data_empty : 1'b1;
            chk("valid", tx.tlp_valid, ev);
            if (ev) begin
                chk("data", tx.tlp_data, b.data);
                chk("sop", tx.tlp_sop, b.sop);
                chk("eop", tx.tlp_eop, b.eop);
                chk("half", tx.tlp_half, b.half);
            end
            acc = ev && tx.tlp_ready;
            chk("p_hdr_rden", p_hdr_rden, acc && m_is_p && b.pop_hdr);
            chk("p_data_rden", p_data_rden, acc && m_is_p && b.pop_data);
            chk("np_hdr_rden", np_hdr_rden, acc && !m_is_p);
            chk("p_sent", p_sent, acc && m_is_p && b.eop);
            if (acc) begin
                if (b.sop) begin
                    if (m_is_p) begin
                        m_ph_c = (m_ph_c + 1) % 256;
                        m_pd_c = (m_pd_c + m_pdreq) % 4096;
                    end else begin
                        m_nph_c = (m_nph_c + 1) % 256;
                    end
                end
                void'(m_beats.pop_front());
                if (b.eop) begin
                    m_busy = 0;
                    sent_now = m_is_p;
                end
            end
        end
        r_ph = p_hdr_rden; r_pd = p_data_rden; r_np = np_hdr_rden;
        @(posedge clk);
        #1;
        if (r_ph && p_hdr_q.size() != 0) void'(p_hdr_q.pop_front());
        if (r_pd && p_data_q.size() != 0) void'(p_data_q.pop_front());
        if (r_np && np_hdr_q.size() != 0) void'(np_hdr_q.pop_front());
        if (sent_now) payload_cnt--;
        drive();
    endtask

    task automatic set_mode(input int mode, input int k);
        case (mode)
            1: tx.tlp_ready = ((k % 4) == 3);
            2: begin
                tx.tlp_ready = ($urandom_range(0, 3) != 0);
                ph_lim  = 8'((m_ph_c + $urandom_range(0, 3)) % 256);
                pd_lim  = 12'((m_pd_c + $urandom_range(0, 24)) % 4096);
                nph_lim = 8'((m_nph_c + $urandom_range(0, 3)) % 256);
                data_hold = ($urandom_range(0, 9) == 0);
            end
            3: begin
                tx.tlp_ready = 1'b1;
                nph_lim = 8'((m_nph_c + 1) % 256);
            end
            default: tx.tlp_ready = 1'b1;
        endcase
        drive();
    endtask

    task automatic run(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            set_mode(mode, k);
            tick();
        end
    endtask

    task automatic drain(input int budget, input int mode);
        int k;
        k = 0;
        while ((m_busy || m_p_q.size() != 0 || m_np_q.size() != 0) && k < budget) begin
            set_mode(mode, k);
            tick();
            k++;
        end
        chk("drain_budget", (m_busy || m_p_q.size() != 0 || m_np_q.size() != 0), 0);
        chk("fifos_drained", p_hdr_q.size() + p_data_q.size() + np_hdr_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p_hdr_q.delete(); p_data_q.delete(); np_hdr_q.delete();
        m_p_q.delete(); m_pd_q.delete(); m_np_q.delete(); m_beats.delete();
        m_busy = 0; m_is_p = 0; m_ph_c = 0; m_pd_c = 0; m_nph_c = 0; m_pdreq = 0;
        payload_cnt = 0; data_hold = 0; tx.tlp_ready = 1'b1;
        drive();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", tx.tlp_valid, 0);
        chk("rst_data", tx.tlp_data, 0);
        chk("rst_sop", tx.tlp_sop, 0);
        chk("rst_eop", tx.tlp_eop, 0);
        chk("rst_half", tx.tlp_half, 0);
        chk("rst_rdens", {p_hdr_rden, p_data_rden, np_hdr_rden, p_sent}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    initial begin
        checks = 0; failures = 0;
        ph_lim = 8'd0; pd_lim = 12'd0; nph_lim = 8'd0;
        do_reset();

        // Single NP read, then 32-DW posted write, backpressure, underrun, 1024-DW write
        ph_lim = 8'd8; pd_lim = 12'd64; nph_lim = 8'd8;
        push_np();
        drain(20, 0);
        push_p(32);
        drain(20, 0);
        push_p(16);
        drain(40, 1);
        push_p(32);
        run(2, 0);
        data_hold = 1'b1;
        run(3, 0);
        data_hold = 1'b0;
        drain(20, 0);
        pd_lim = 12'((m_pd_c + 300) % 4096);
        push_p(0);
        drain(200, 0);

        // Credit starvation on PD, released by raising the limit
        do_reset();
        ph_lim = 8'd8; nph_lim = 8'd8; pd_lim = 12'd4;
        push_p(32);
        run(10, 0);
        pd_lim = 12'd8;
        drain(12, 0);

        // Simultaneous P and NP
        do_reset();
        ph_lim = 8'd8; pd_lim = 12'd64; nph_lim = 8'd8;
        push_p(16);
        push_np();
        drain(20, 0);

        // NPH counter wrap, then stall with limit equal to consumed
        do_reset();
        for (int i = 0; i < 260; i++) push_np();
        drain(1000, 3);
        nph_lim = 8'(m_nph_c);
        push_np();
        run(6, 0);
        nph_lim = 8'((m_nph_c + 1) % 256);
        drain(10, 0);

        // Reset in the middle of a posted TLP
        do_reset();
        ph_lim = 8'd8; pd_lim = 12'd64; nph_lim = 8'd8;
        push_p(64);
        run(4, 0);
        do_reset();
        ph_lim = 8'd8; pd_lim = 12'd64; nph_lim = 8'd8;
        push_np();
        drain(10, 0);

        // Randomized traffic, ready, limits and data underruns
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0 && payload_cnt < 6) push_p(8 * $urandom_range(1, 8));
            if ($urandom_range(0, 9) == 0 && np_hdr_q.size() < 8) push_np();
            set_mode(2, i);
            tick();
        end
        drain(3000, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
